// File: rtl/amem_pkg.sv
// ============================================================================
// Module : amem_pkg
// Brief  : Shared widths, depth and FSM state type for the A-memory port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package amem_pkg;

    localparam int AMEM_AW    = 10;
    localparam int AMEM_DW    = 32;
    localparam int AMEM_DEPTH = 1024;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } amem_state_t;

endpackage

`default_nettype wire

// File: rtl/amem_ram.sv
// ============================================================================
// Module : amem_ram
// Brief  : Simple dual-port synchronous RAM, read-old on same-address collision.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module amem_ram
    import amem_pkg::*;
#(
    parameter int AW    = AMEM_AW,
    parameter int DW    = AMEM_DW,
    parameter int DEPTH = AMEM_DEPTH
) (
    input  logic          clk,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          we_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          re_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] q_q;

    // Non-blocking write and read in one block gives read-old behaviour.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            q_q <= mem_q[raddr_i];
        end
    end

    assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/amem_port.sv
// ============================================================================
// Module : amem_port
// Brief  : 1024x32 A-memory with post-reset clear; AMEM_PASS_EN adds
//          write-to-read forwarding through a pass register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module amem_port
    import amem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [AMEM_AW-1:0] aadr,
    input  logic               arp,
    input  logic               awp,
    input  logic [AMEM_DW-1:0] wdata,
    output logic [AMEM_DW-1:0] amem,
    output logic               init_busy
);

    localparam logic [AMEM_AW-1:0] CNT_LAST = AMEM_AW'(AMEM_DEPTH - 1);

    amem_state_t        state_q;
    logic [AMEM_AW-1:0] init_cnt_q;
    logic               init_busy_q;
    logic               zero_q;

    logic               run_d;
    logic               ram_we_d;
    logic               ram_re_d;
    logic [AMEM_AW-1:0] ram_waddr_d;
    logic [AMEM_DW-1:0] ram_wdata_d;
    logic [AMEM_DW-1:0] ram_q;

    // Host strobes only reach the array once the clear has finished.
    assign run_d       = (state_q == RUN) && !reset;
    assign ram_we_d    = run_d ? awp : 1'b1;
    assign ram_waddr_d = run_d ? aadr : init_cnt_q;
    assign ram_wdata_d = run_d ? wdata : '0;
    assign ram_re_d    = run_d && arp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
            zero_q      <= 1'b1;
        end else begin
            unique case (state_q)
                INIT: begin
                    zero_q <= 1'b1;
                    if (init_cnt_q == CNT_LAST) begin
                        state_q     <= RUN;
                        init_busy_q <= 1'b0;
                    end else begin
                        init_cnt_q <= init_cnt_q + AMEM_AW'(1);
                    end
                end
                RUN: begin
                    if (arp) begin
                        zero_q <= 1'b0;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    amem_ram #(
        .AW    (AMEM_AW),
        .DW    (AMEM_DW),
        .DEPTH (AMEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .waddr_i (ram_waddr_d),
        .wdata_i (ram_wdata_d),
        .we_i    (ram_we_d),
        .raddr_i (aadr),
        .re_i    (ram_re_d),
        .q_o     (ram_q)
    );

`ifdef AMEM_PASS_EN
    logic [AMEM_AW-1:0] pass_addr_q;
    logic [AMEM_DW-1:0] pass_data_q;
    logic               pass_vld_q;
    logic               fwd_sel_q;
    logic [AMEM_DW-1:0] fwd_data_q;
    logic               fwd_hit_d;
    logic [AMEM_DW-1:0] fwd_val_d;

    // A same-cycle write is newer than the pass register, so it wins.
    assign fwd_hit_d = awp || (pass_vld_q && (pass_addr_q == aadr));
    assign fwd_val_d = awp ? wdata : pass_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pass_vld_q <= 1'b0;
            fwd_sel_q  <= 1'b0;
        end else begin
            pass_vld_q <= run_d && awp;
            if (ram_re_d) begin
                fwd_sel_q <= fwd_hit_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (run_d && awp) begin
            pass_addr_q <= aadr;
            pass_data_q <= wdata;
        end
        if (ram_re_d) begin
            fwd_data_q <= fwd_val_d;
        end
    end

    assign amem = zero_q ? '0 : (fwd_sel_q ? fwd_data_q : ram_q);
`else
    assign amem = zero_q ? '0 : ram_q;
`endif

    assign init_busy = init_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_amem_port.sv
// ============================================================================
// Module : tb_amem_port
// Brief  : Directed scoreboard bench for amem_port (AMEM_PASS_EN optional).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_amem_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arp = 1'b0;
    logic        awp = 1'b0;
    logic [9:0]  aadr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] amem;
    logic        init_busy;

    typedef struct {
        string       name;
        logic [31:0] amem;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_go = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    amem_port dut (
        .clk       (clk),
        .reset     (reset),
        .aadr      (aadr),
        .arp       (arp),
        .awp       (awp),
        .wdata     (wdata),
        .amem      (amem),
        .init_busy (init_busy)
    );

    // One bus cycle; when chk is set, the state after the coming edge is expected.
    task automatic cyc(input bit r, input bit rd, input bit wr, input logic [9:0] a,
                       input logic [31:0] d, input bit chk, input string nm,
                       input logic [31:0] ea, input bit eb);
        exp_t e;
        @(negedge clk);
        reset = r; arp = rd; awp = wr; aadr = a; wdata = d; mon_go = chk;
        if (chk) begin
            e.name = nm; e.amem = ea; e.busy = eb;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, "", 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [9:0] a, input string nm, input logic [31:0] ea);
        cyc(1'b0, 1'b1, 1'b0, a, 32'h0, 1'b1, nm, ea, 1'b0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b0, 1'b1, a, d, 1'b0, "", 32'h0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (mon_go) begin
                #1;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: no expected entry at t=%0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    if (amem !== e.amem || init_busy !== e.busy) begin
                        n_fail++;
                        $display("FAIL %s: got amem=%h init_busy=%b, expected amem=%h init_busy=%b",
                                 e.name, amem, init_busy, e.amem, e.busy);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] exp_coll;
`ifdef AMEM_PASS_EN
        exp_coll = 32'h2222_2222;
`else
        exp_coll = 32'h1111_1111;
`endif
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, "reset", 32'h0, 1'b1);
        for (int k = 1; k <= 1024; k++)
            cyc(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, "init_busy", 32'h0, k < 1024);

        rd(10'h3FF, "rd_3ff_cleared", 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 10'h155, 32'hDEAD_BEEF, 1'b1, "hold_zero_on_write", 32'h0, 1'b0);
        idle(); idle();
        rd(10'h155, "rd_155", 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, "hold_155", 32'hDEAD_BEEF, 1'b0);

        wr(10'h010, 32'h1111_1111);
        idle();
        cyc(1'b0, 1'b1, 1'b1, 10'h010, 32'h2222_2222, 1'b1, "rw_collision_010", exp_coll, 1'b0);
        idle();
        rd(10'h010, "rd_after_collision_010", 32'h2222_2222);

        cyc(1'b0, 1'b0, 1'b1, 10'h020, 32'hCAFE_F00D, 1'b1, "hold_on_write_020", 32'h2222_2222, 1'b0);
        rd(10'h020, "rd_after_wr_020", 32'hCAFE_F00D);

        wr(10'h021, 32'h0BAD_C0DE);
        idle();
        wr(10'h020, 32'h1234_5678);
        rd(10'h021, "no_fwd_021", 32'h0BAD_C0DE);
        rd(10'h020, "rd_020_new", 32'h1234_5678);

        // Restart the clear, then pulse reset again at init_cnt=500.
        cyc(1'b1, 1'b1, 1'b1, 10'h155, 32'hFFFF_FFFF, 1'b1, "reset2", 32'h0, 1'b1);
        for (int k = 1; k <= 500; k++)
            cyc(1'b0, 1'b1, 1'b1, 10'(k), 32'hFFFF_FFFF, 1'b1, "init2_partial", 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, "reset_mid_init", 32'h0, 1'b1);
        for (int k = 1; k <= 1024; k++)
            cyc(1'b0, 1'b1, 1'b1, 10'((k + 512) % 1024), 32'hA5A5_A5A5, 1'b1,
                "init3_busy", 32'h0, k < 1024);
        for (int a = 0; a < 1024; a++)
            rd(10'(a), "rd_cleared", 32'h0);
        idle(); idle(); idle();

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
